// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The slave modport is the decode stage itself; master is its environment.
interface decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instruction;
    logic [PC_WIDTH-1:0] in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [4:0]          rs1_address;
    logic [4:0]          rs2_address;
    logic [4:0]          rd_address;
    logic [XLEN-1:0]     imm;
    logic [3:0]          alu_rd_operator;
    logic [1:0]          alu_rd_operand1_src;
    logic [2:0]          alu_rd_operand2_src;
    logic [1:0]          alu_pc_operand1_src;
    logic [1:0]          next_pc_src;
    logic                reg_write_data_src;
    logic                reg_wren;
    logic                ram_wren;
    logic [2:0]          mem_funct3;
    logic                illegal;

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1_address, rs2_address, rd_address,
               imm, alu_rd_operator, alu_rd_operand1_src, alu_rd_operand2_src,
               alu_pc_operand1_src, next_pc_src, reg_write_data_src, reg_wren,
               ram_wren, mem_funct3, illegal
    );

    modport master (
        output in_valid, in_instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1_address, rs2_address, rd_address,
               imm, alu_rd_operator, alu_rd_operand1_src, alu_rd_operand2_src,
               alu_pc_operand1_src, next_pc_src, reg_write_data_src, reg_wren,
               ram_wren, mem_funct3, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage: instruction decode, immediate sign extension,
// illegal-instruction detection and a 2-entry skid buffer towards execute.
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int PC_WIDTH    = 32,
    parameter int SKID_ENABLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9;

    localparam logic [1:0] OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_IMM = 2'd2;
    localparam logic [2:0] OP2_RS2 = 3'd0, OP2_IMM = 3'd1, OP2_FOUR = 3'd2, OP2_ZERO = 3'd3;
    localparam logic [1:0] PCOP1_PC = 2'd0, PCOP1_RS1 = 2'd1;
    localparam logic [1:0] NPC_NOT_BRANCH = 2'd0, NPC_ON_ZERO = 2'd1;
    localparam logic [1:0] NPC_ON_NON_ZERO = 2'd2, NPC_ALWAYS = 2'd3;
    localparam logic       WDATA_ALU = 1'b0, WDATA_MEM = 1'b1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [3:0]          alu_op;
        logic [1:0]          op1_src;
        logic [2:0]          op2_src;
        logic [1:0]          pc_op1_src;
        logic [1:0]          next_pc_src;
        logic                wdata_src;
        logic                reg_wren;
        logic                ram_wren;
        logic [2:0]          mem_funct3;
        logic                illegal;
    } bundle_t;

    function automatic logic [3:0] alu_op_f(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0]     inst;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            legal;
    logic            shift_ok;
    bundle_t         dec;

    assign inst   = bus.in_instruction;
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = XLEN'($signed(inst[31:20]));
    assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // On RV64 inst[25] belongs to the 6-bit shift amount, so only funct7[6:1] is checked.
    always_comb begin
        shift_ok = 1'b1;
        if (XLEN == 64) begin
            if (funct3 == 3'b001)      shift_ok = (inst[31:26] == 6'b000000);
            else if (funct3 == 3'b101) shift_ok = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
        end else begin
            if (funct3 == 3'b001)      shift_ok = (funct7 == 7'h00);
            else if (funct3 == 3'b101) shift_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
    end

    always_comb begin
        dec             = '0;
        legal           = 1'b1;
        dec.pc          = bus.in_pc;
        dec.rs1         = inst[19:15];
        dec.rs2         = inst[24:20];
        dec.rd          = inst[11:7];
        dec.op1_src     = OP1_RS1;
        dec.op2_src     = OP2_RS2;
        dec.pc_op1_src  = PCOP1_PC;
        dec.next_pc_src = NPC_NOT_BRANCH;
        dec.wdata_src   = WDATA_ALU;
        case (inst[6:0])
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.alu_op   = alu_op_f(funct3, inst[30]);
                dec.reg_wren = 1'b1;
            end
            OPC_OP_IMM: begin
                legal        = shift_ok;
                dec.alu_op   = alu_op_f(funct3, (funct3 == 3'b101) && inst[30]);
                dec.op2_src  = OP2_IMM;
                dec.imm      = imm_i;
                dec.reg_wren = 1'b1;
            end
            OPC_LOAD: begin
                legal          = !((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)));
                dec.alu_op     = ALU_ADD;
                dec.op2_src    = OP2_IMM;
                dec.imm        = imm_i;
                dec.reg_wren   = 1'b1;
                dec.wdata_src  = WDATA_MEM;
                dec.mem_funct3 = funct3;
            end
            OPC_STORE: begin
                legal          = !((XLEN == 32) && (funct3 > 3'b010));
                dec.alu_op     = ALU_ADD;
                dec.op2_src    = OP2_IMM;
                dec.imm        = imm_s;
                dec.ram_wren   = 1'b1;
                dec.mem_funct3 = funct3;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                case (funct3)
                    3'b000:  begin dec.alu_op = ALU_SUB;  dec.next_pc_src = NPC_ON_ZERO;     end
                    3'b001:  begin dec.alu_op = ALU_SUB;  dec.next_pc_src = NPC_ON_NON_ZERO; end
                    3'b100:  begin dec.alu_op = ALU_SLT;  dec.next_pc_src = NPC_ON_NON_ZERO; end
                    3'b101:  begin dec.alu_op = ALU_SLT;  dec.next_pc_src = NPC_ON_ZERO;     end
                    3'b110:  begin dec.alu_op = ALU_SLTU; dec.next_pc_src = NPC_ON_NON_ZERO; end
                    3'b111:  begin dec.alu_op = ALU_SLTU; dec.next_pc_src = NPC_ON_ZERO;     end
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                legal           = (inst[6:0] == OPC_JAL) || (funct3 == 3'b000);
                dec.alu_op      = ALU_ADD;
                dec.op1_src     = OP1_PC;
                dec.op2_src     = OP2_FOUR;
                dec.pc_op1_src  = (inst[6:0] == OPC_JAL) ? PCOP1_PC : PCOP1_RS1;
                dec.imm         = (inst[6:0] == OPC_JAL) ? imm_j : imm_i;
                dec.next_pc_src = NPC_ALWAYS;
                dec.reg_wren    = 1'b1;
            end
            OPC_AUIPC, OPC_LUI: begin
                dec.alu_op   = ALU_ADD;
                dec.op1_src  = (inst[6:0] == OPC_LUI) ? OP1_IMM : OP1_PC;
                dec.op2_src  = (inst[6:0] == OPC_LUI) ? OP2_ZERO : OP2_IMM;
                dec.imm      = imm_u;
                dec.reg_wren = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal words still travel down the pipe with only PC and the flag so execute can trap.
        if (!legal) begin
            dec             = '0;
            dec.pc          = bus.in_pc;
            dec.next_pc_src = NPC_NOT_BRANCH;
            dec.illegal     = 1'b1;
        end
    end

    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    ready_q, ready_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    in_ready;
    logic    accept;
    logic    consume;

    // In skid mode in_ready is purely registered; the 1-entry variant looks through out_ready.
    assign in_ready = (SKID_ENABLE != 0) ? ready_q : (ready_q & (~main_valid_q | bus.out_ready));
    assign accept   = bus.in_valid & in_ready;
    assign consume  = main_valid_q & bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume || !main_valid_q) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        ready_d = (SKID_ENABLE != 0) ? !skid_valid_d : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.in_ready            = in_ready;
    assign bus.out_valid           = main_valid_q;
    assign bus.out_pc              = main_q.pc;
    assign bus.rs1_address         = main_q.rs1;
    assign bus.rs2_address         = main_q.rs2;
    assign bus.rd_address          = main_q.rd;
    assign bus.imm                 = main_q.imm;
    assign bus.alu_rd_operator     = main_q.alu_op;
    assign bus.alu_rd_operand1_src = main_q.op1_src;
    assign bus.alu_rd_operand2_src = main_q.op2_src;
    assign bus.alu_pc_operand1_src = main_q.pc_op1_src;
    assign bus.next_pc_src         = main_q.next_pc_src;
    assign bus.reg_write_data_src  = main_q.wdata_src;
    assign bus.reg_wren            = main_q.reg_wren;
    assign bus.ram_wren            = main_q.ram_wren;
    assign bus.mem_funct3          = main_q.mem_funct3;
    assign bus.illegal             = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// scored against an instruction-level decode model and a FIFO occupancy model.
module tb_decode_stage;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9;
    localparam logic [1:0] OP1_PC = 2'd1, OP1_IMM = 2'd2;
    localparam logic [2:0] OP2_IMM = 3'd1, OP2_FOUR = 3'd2, OP2_ZERO = 3'd3;
    localparam logic [1:0] PCOP1_PC = 2'd0, PCOP1_RS1 = 2'd1;
    localparam logic [1:0] NPC_NOT = 2'd0, NPC_ZERO = 2'd1, NPC_NONZERO = 2'd2, NPC_ALWAYS = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic [1:0]  pcop1;
        logic [1:0]  npc;
        logic        wsrc;
        logic        rwe;
        logic        mwe;
        logic [2:0]  mf3;
        logic        ill;
    } bundle_t;

    logic [3:0] f3_ops [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [3:0] br_ops [8] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
    logic [1:0] br_npc [8] = '{NPC_ZERO, NPC_NONZERO, NPC_NOT, NPC_NOT, NPC_NONZERO, NPC_ZERO, NPC_NONZERO, NPC_ZERO};
    logic [6:0] opcodes [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;

    decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

    decode_stage #(.XLEN(32), .PC_WIDTH(32), .SKID_ENABLE(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction-level decode: immediates built from arithmetic shifts, fields from mnemonic tables.
    function automatic bundle_t model(input logic [31:0] w, input logic [31:0] pc);
        bundle_t e;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [31:0] sw;
        logic [31:0] ii, is, ib, iu, ij;
        sw = w;
        f3 = w[14:12];
        f7 = w[31:25];
        ii = 32'(sw >>> 20);
        is = {ii[31:5], w[11:7]};
        ib = (32'(sw >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        iu = {w[31:12], 12'h000};
        ij = (32'(sw >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        e = '0;
        e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        ok = 1'b1;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.op = f3_ops[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_SRA;
                e.rwe = 1'b1;
            end
            7'h13: begin
                e.op = f3_ops[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
                e.op2 = OP2_IMM; e.imm = ii; e.rwe = 1'b1;
            end
            7'h03: begin
                ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
                e.op = ALU_ADD; e.op2 = OP2_IMM; e.imm = ii; e.rwe = 1'b1; e.wsrc = 1'b1; e.mf3 = f3;
            end
            7'h23: begin
                ok = (f3 <= 3'd2);
                e.op = ALU_ADD; e.op2 = OP2_IMM; e.imm = is; e.mwe = 1'b1; e.mf3 = f3;
            end
            7'h63: begin
                ok = !(f3 == 3'd2 || f3 == 3'd3);
                e.op = br_ops[f3]; e.npc = br_npc[f3]; e.imm = ib; e.pcop1 = PCOP1_PC;
            end
            7'h6F: begin
                e.op = ALU_ADD; e.op1 = OP1_PC; e.op2 = OP2_FOUR; e.imm = ij;
                e.npc = NPC_ALWAYS; e.pcop1 = PCOP1_PC; e.rwe = 1'b1;
            end
            7'h67: begin
                ok = (f3 == 3'd0);
                e.op = ALU_ADD; e.op1 = OP1_PC; e.op2 = OP2_FOUR; e.imm = ii;
                e.npc = NPC_ALWAYS; e.pcop1 = PCOP1_RS1; e.rwe = 1'b1;
            end
            7'h17: begin e.op = ALU_ADD; e.op1 = OP1_PC; e.op2 = OP2_IMM; e.imm = iu; e.rwe = 1'b1; end
            7'h37: begin e.op = ALU_ADD; e.op1 = OP1_IMM; e.op2 = OP2_ZERO; e.imm = iu; e.rwe = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.pc = pc;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic bundle_t observe();
        bundle_t b;
        b.pc = bus.out_pc; b.rs1 = bus.rs1_address; b.rs2 = bus.rs2_address; b.rd = bus.rd_address;
        b.imm = bus.imm; b.op = bus.alu_rd_operator; b.op1 = bus.alu_rd_operand1_src;
        b.op2 = bus.alu_rd_operand2_src; b.pcop1 = bus.alu_pc_operand1_src; b.npc = bus.next_pc_src;
        b.wsrc = bus.reg_write_data_src; b.rwe = bus.reg_wren; b.mwe = bus.ram_wren;
        b.mf3 = bus.mem_funct3; b.ill = bus.illegal;
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int sel;
        w = $urandom();
        sel = $urandom_range(0, 11);
        if (sel < 9) w[6:0] = opcodes[sel];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic ordy, input logic fl);
        bus.in_valid = v; bus.in_instruction = w; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
    endtask

    task automatic test_reset();
        bundle_t got;
        #2;
        got = observe();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (got !== bundle_t'(0)) begin errors++; $display("[TB] FAIL reset_bundle got=%h exp=0", got); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_directed();
        bundle_t got;
        @(negedge clk); drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        got = observe();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({got.rd, got.rs1, got.imm, got.op, got.rwe, got.ill} !== {5'd1, 5'd0, 32'hFFFFFFFF, ALU_ADD, 1'b1, 1'b0})
            begin errors++; $display("[TB] FAIL addi_fields got rd=%0d rs1=%0d imm=%h op=%0d rwe=%b ill=%b", got.rd, got.rs1, got.imm, got.op, got.rwe, got.ill); end
        checks++; if (got !== model(32'hFFF00093, 32'h100)) begin errors++; $display("[TB] FAIL addi_bundle got=%h exp=%h", got, model(32'hFFF00093, 32'h100)); end
        drive(1'b1, 32'hFE20AE23, 32'h104, 1'b1, 1'b0);
        @(negedge clk);
        got = observe();
        checks++; if ({got.imm, got.rs1, got.rs2, got.mwe, got.rwe, got.mf3} !== {32'hFFFFFFFC, 5'd1, 5'd2, 1'b1, 1'b0, 3'b010})
            begin errors++; $display("[TB] FAIL sw_fields got imm=%h rs1=%0d rs2=%0d mwe=%b rwe=%b mf3=%0d", got.imm, got.rs1, got.rs2, got.mwe, got.rwe, got.mf3); end
        checks++; if (got.pc !== 32'h104) begin errors++; $display("[TB] FAIL sw_pc got=%h exp=104", got.pc); end
        drive(1'b1, 32'hFE000CE3, 32'h108, 1'b1, 1'b0);
        @(negedge clk);
        got = observe();
        checks++; if ({got.imm, got.op, got.npc} !== {32'hFFFFFFF8, ALU_SUB, NPC_ZERO})
            begin errors++; $display("[TB] FAIL beq_fields got imm=%h op=%0d npc=%0d", got.imm, got.op, got.npc); end
        checks++; if (got !== model(32'hFE000CE3, 32'h108)) begin errors++; $display("[TB] FAIL beq_bundle got=%h exp=%h", got, model(32'hFE000CE3, 32'h108)); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL directed_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        bundle_t got;
        words = '{32'h00000000, 32'h02208033, 32'h0000A063};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = observe();
                checks++; if ({bus.out_valid, got.ill, got.rwe, got.mwe, got.npc} !== {1'b1, 1'b1, 1'b0, 1'b0, NPC_NOT})
                    begin errors++; $display("[TB] FAIL illegal_%0d got valid=%b ill=%b rwe=%b mwe=%b npc=%0d", i - 1, bus.out_valid, got.ill, got.rwe, got.mwe, got.npc); end
                checks++; if (got !== model(words[i-1], 32'h200 + 32'(i))) begin errors++; $display("[TB] FAIL illegal_bundle_%0d got=%h exp=%h", i - 1, got, model(words[i-1], 32'h200 + 32'(i))); end
            end
            if (i < 3) drive(1'b1, words[i], 32'h201 + 32'(i), 1'b1, 1'b0);
            else       drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        logic [31:0] seen [$];
        int seen_cyc [$];
        int idx;
        bundle_t got;
        words = '{32'h00100093, 32'h00208113, 32'h002081B3, 32'h40310233};
        idx = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                got = observe();
                checks++; if (bus.out_valid !== 1'b1 || got !== model(words[0], 32'h300))
                    begin errors++; $display("[TB] FAIL b2b_hold_c%0d got valid=%b bundle=%h exp=%h", c, bus.out_valid, got, model(words[0], 32'h300)); end
            end
            if (c == 3 || c == 4) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_in_ready_c%0d got=%b exp=0", c, bus.in_ready); end
            end
            drive(idx < 4, (idx < 4) ? words[idx] : 32'h0, 32'h300 + 32'(idx * 4), c >= 5, 1'b0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                seen.push_back(bus.out_pc);
                seen_cyc.push_back(c);
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        checks++; if (seen.size() != 4) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            checks++; if (seen[k] !== 32'h300 + 32'(k * 4) || seen_cyc[k] != 5 + k)
                begin errors++; $display("[TB] FAIL b2b_order_%0d got pc=%h cyc=%0d exp pc=%h cyc=%0d", k, seen[k], seen_cyc[k], 32'h300 + 32'(k * 4), 5 + k); end
        end
    endtask

    task automatic test_flush();
        int leaked;
        @(negedge clk); drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h400) begin errors++; $display("[TB] FAIL flush_full got in_ready=%b pc=%h exp 0/400", bus.in_ready, bus.out_pc); end
        drive(1'b1, 32'h00300093, 32'h408, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_full_after got valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
        drive(1'b1, 32'h00400093, 32'h40C, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h00500093, 32'h410, 1'b0, 1'b1);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_accept_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_accept_after got valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        leaked = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("[TB] FAIL flush_leak got=%0d exp=0", leaked); end
        drive(1'b1, 32'h00600093, 32'h414, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h414) begin errors++; $display("[TB] FAIL flush_resume got valid=%b pc=%h exp 1/414", bus.out_valid, bus.out_pc); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        bundle_t got;
        @(negedge clk); drive(1'b1, 32'h12345037, 32'h500, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got=%b exp=1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async got valid=%b in_ready=%b exp 0/0", bus.out_valid, bus.in_ready); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got=%b exp=1", bus.in_ready); end
        drive(1'b1, 32'h00C58513, 32'h504, 1'b0, 1'b0);
        @(negedge clk);
        got = observe();
        checks++; if (bus.out_valid !== 1'b1 || got !== model(32'h00C58513, 32'h504))
            begin errors++; $display("[TB] FAIL midrst_first got valid=%b bundle=%h exp=%h", bus.out_valid, got, model(32'h00C58513, 32'h504)); end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        bundle_t q [$];
        bundle_t got;
        logic acc, con;
        int stall_pct;
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            got = observe();
            checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, q.size() != 0); end
            checks++; if (bus.in_ready !== (q.size() < 2)) begin errors++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, q.size() < 2); end
            if (q.size() != 0) begin
                checks++; if (got !== q[0]) begin errors++; $display("[TB] FAIL rand_bundle cyc=%0d got=%h exp=%h", cyc, got, q[0]); end
            end
            stall_pct = ((cyc / 500) % 3 == 0) ? 10 : (((cyc / 500) % 3 == 1) ? 50 : 80);
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom() & 32'hFFFFFFFC,
                  $urandom_range(0, 99) >= stall_pct, $urandom_range(0, 49) == 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            con = bus.out_valid && bus.out_ready;
            if (flush) q.delete();
            else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(model(bus.in_instruction, bus.in_pc));
            end
        end
        @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
